// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and NZCV flag layout.
package alu_pkg;

  // 3-bit opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DONE     = 2'd2
  } state_e;

  // Bit positions inside the packed NZCV vector
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef logic [3:0] nzcv_t;

  // Assemble a flag vector from its individual bits
  function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU: arithmetic, logic and shifts with NZCV flags.
// MUL yields zero here; the iterative multiplier lives in the sequential wrapper.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output nzcv_t            flags_o
);

  localparam int SHW = $clog2(WIDTH);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  // SUB reuses the adder as A + ~B + 1, so carry-out means "no borrow"
  assign is_sub = (op_i == OP_SUB);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  // One extra bit on each shifter catches the last bit shifted out (zero for sh=0)
  assign sh  = b_i[SHW-1:0];
  assign shl = {1'b0, a_i} << sh;
  assign shr = {a_i, 1'b0} >> sh;

  // Select the result and the C/V flags for the current opcode
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_LSL: begin
        res   = shl[WIDTH-1:0];
        carry = shl[WIDTH];
      end
      OP_LSR: begin
        res   = shr[WIDTH:1];
        carry = shr[0];
      end
      default: ;
    endcase
  end

  assign result_o = res;
  assign flags_o  = pack_nzcv(res[WIDTH-1], (res == '0), carry, ovf);

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: registers result and NZCV behind valid/ready, with an optional
// iterative shift-add multiplier (one partial product per clock).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  nzcv_t            flags_q, flags_d;

  logic [WIDTH-1:0] comb_result;
  nzcv_t            comb_flags;
  logic [WIDTH-1:0] acc_step;
  logic             accept;
  logic             start_mul;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i     (SrcA),
    .b_i     (SrcB),
    .op_i    (ALUControl),
    .result_o(comb_result),
    .flags_o (comb_flags)
  );

  // A new op can enter when idle, or when the held result is leaving this cycle
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = MUL_EN && (ALUControl == OP_MUL);

  // Accumulator value after adding the current partial product
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and datapath update: iterate the multiply, drain DONE, then load any accepted op
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_MUL_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d = acc_step;
          flags_d  = pack_nzcv(acc_step[WIDTH-1], (acc_step == '0), 1'b0, 1'b0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or a draining DONE, so it overrides both
    if (accept) begin
      if (start_mul) begin
        mcand_d  = SrcA;
        mplier_d = SrcB;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH - 1);
        state_d  = S_MUL_BUSY;
      end else begin
        result_d = comb_result;
        flags_d  = comb_flags;
        state_d  = S_DONE;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL_BUSY);
  assign ALUResult = result_q;
  assign Negative  = flags_q[FLAG_N];
  assign Zero      = flags_q[FLAG_Z];
  assign Carry     = flags_q[FLAG_C];
  assign Overflow  = flags_q[FLAG_V];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance, directed and random
// ops checked against an arithmetic reference model; monitors pop on each output handshake.
module tb_seq_alu;

  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR  = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4, T_LSL = 3'd5, T_LSR = 3'd6, T_MUL = 3'd7;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  nzcv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance signals
  logic        rst32_n, v32, rdy32, ov32, ordy32, z32, n32, c32, o32, busy32;
  logic [31:0] a32, b32, res32;
  logic [2:0]  op32;
  // 8-bit instance signals
  logic        rst8_n, v8, rdy8, ov8, ordy8, z8, n8, c8, o8, busy8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;

  seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) u_alu32 (
    .clk(clk), .reset_n(rst32_n), .in_valid(v32), .in_ready(rdy32),
    .SrcA(a32), .SrcB(b32), .ALUControl(op32), .out_valid(ov32), .out_ready(ordy32),
    .ALUResult(res32), .Zero(z32), .Negative(n32), .Carry(c32), .Overflow(o32), .busy(busy32)
  );

  seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) u_alu8 (
    .clk(clk), .reset_n(rst8_n), .in_valid(v8), .in_ready(rdy8),
    .SrcA(a8), .SrcB(b8), .ALUControl(op8), .out_valid(ov8), .out_ready(ordy8),
    .ALUResult(res8), .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(o8), .busy(busy8)
  );

  exp_t q32[$];
  exp_t q8[$];
  int   pops32[$];
  exp_t e32, e8;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] f);
    exp_t e;
    e.res  = r;
    e.nzcv = f;
    return e;
  endfunction

  // Reference model: plain unsigned arithmetic on w-bit values held in 64-bit integers
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [31:0] a_in, input logic [31:0] b_in);
    longint unsigned mask, a, b, r, full;
    int   sh;
    logic c, v, sa, sb;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    a    = {32'd0, a_in} & mask;
    b    = {32'd0, b_in} & mask;
    sh   = int'(b % longint'(w));
    sa   = a[w-1];
    sb   = b[w-1];
    r    = 0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      T_ADD: begin
        full = a + b;
        r    = full & mask;
        c    = full[w];
        v    = (sa == sb) && (r[w-1] != sa);
      end
      T_SUB: begin
        r = (a - b) & mask;
        c = (a >= b);
        v = (sa != sb) && (r[w-1] != sa);
      end
      T_AND: r = a & b;
      T_OR:  r = a | b;
      T_XOR: r = a ^ b;
      T_LSL: begin
        r = (a << sh) & mask;
        c = (sh != 0) ? a[w-sh] : 1'b0;
      end
      T_LSR: begin
        r = a >> sh;
        c = (sh != 0) ? a[sh-1] : 1'b0;
      end
      default: r = (a * b) & mask;
    endcase
    e.res  = r[31:0];
    e.nzcv = {r[w-1], (r == 0), c, v};
    return e;
  endfunction

  // Monitors: compare on every completed output handshake
  always @(negedge clk) begin
    if (rst32_n && ov32 && ordy32) begin
      if (q32.size() == 0) check("sb32_unexpected_output", ov32, 1'b0);
      else begin
        e32 = q32.pop_front();
        check("sb32_result", res32, e32.res);
        check("sb32_nzcv", {n32, z32, c32, o32}, e32.nzcv);
        pops32.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst8_n && ov8 && ordy8) begin
      if (q8.size() == 0) check("sb8_unexpected_output", ov8, 1'b0);
      else begin
        e8 = q8.pop_front();
        check("sb8_result", res8, e8.res);
        check("sb8_nzcv", {n8, z8, c8, o8}, e8.nzcv);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ordy(input int w, input logic val);
    if (w == 8) ordy8 = val;
    else ordy32 = val;
  endtask

  // Present one op; push its expectation on the accept edge. Caller sits just after a posedge.
  task automatic issue(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e, input bit bp);
    bit accepted = 1'b0;
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; op8 = op; v8 = 1'b1;
    end else begin
      a32 = a; b32 = b; op32 = op; v32 = 1'b1;
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((w == 8) ? rdy8 : rdy32) begin
        if (w == 8) q8.push_back(e);
        else q32.push_back(e);
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (bp) set_ordy(w, ($urandom_range(0, 2) != 0));
    end
    if (w == 8) v8 = 1'b0;
    else v32 = 1'b0;
    check("accept_within_bound", accepted, 1'b1);
  endtask

  // Let every queued result drain with out_ready held high
  task automatic drain(input int w);
    set_ordy(w, 1'b1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (((w == 8) ? q8.size() : q32.size()) == 0) break;
    end
    check("drain_empty", (w == 8) ? q8.size() : q32.size(), 0);
    sync();
  endtask

  // Count edges from accept (inclusive) to out_valid, plus busy/in_ready cycles meanwhile
  task automatic measure(input int w, output int lat, output int busy_cnt, output int rdy_cnt);
    lat = 1; busy_cnt = 0; rdy_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((w == 8) ? ov8 : ov32) break;
      if ((w == 8) ? busy8 : busy32) busy_cnt++;
      if ((w == 8) ? rdy8 : rdy32) rdy_cnt++;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   lat, bcnt, rcnt, base;
    logic [2:0]  op;
    logic [31:0] ra, rb;

    v32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; ordy32 = 1'b1; rst32_n = 1'b0;
    v8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; ordy8  = 1'b1; rst8_n  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst32_out_valid", ov32, 1'b0);
    check("rst32_result", res32, 32'd0);
    check("rst32_nzcv", {n32, z32, c32, o32}, 4'b0000);
    check("rst32_busy", busy32, 1'b0);
    check("rst32_in_ready", rdy32, 1'b1);
    check("rst8_out_valid", ov8, 1'b0);
    check("rst8_result", res8, 8'd0);
    check("rst8_busy", busy8, 1'b0);
    sync();
    rst32_n = 1'b1;
    rst8_n  = 1'b1;

    // Directed single-cycle ops, WIDTH=32, issued back to back
    issue(32, T_ADD, 32'h0000_0004, 32'h0000_0005, mk(32'h0000_0009, 4'b0000), 1'b0);
    issue(32, T_SUB, 32'h0000_0004, 32'h0000_0005, mk(32'hFFFF_FFFF, 4'b1000), 1'b0);
    issue(32, T_SUB, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 4'b0011), 1'b0);
    issue(32, T_ADD, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 4'b0110), 1'b0);
    issue(32, T_LSL, 32'h8000_0001, 32'h0000_0001, mk(32'h0000_0002, 4'b0010), 1'b0);
    issue(32, T_LSR, 32'h0000_0003, 32'h0000_0001, mk(32'h0000_0001, 4'b0010), 1'b0);
    issue(32, T_LSL, 32'h0000_1234, 32'h0000_0000, mk(32'h0000_1234, 4'b0000), 1'b0);
    issue(32, T_LSR, 32'h0000_00A5, 32'h0000_0020, mk(32'h0000_00A5, 4'b0000), 1'b0);
    issue(32, T_LSR, 32'h8000_0000, 32'h0000_001F, mk(32'h0000_0001, 4'b0000), 1'b0);
    issue(32, T_LSL, 32'h0000_0001, 32'h0000_001F, mk(32'h8000_0000, 4'b1000), 1'b0);
    issue(32, T_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 4'b1000), 1'b0);
    issue(32, T_OR,  32'h0000_0000, 32'h0000_0000, mk(32'h0000_0000, 4'b0100), 1'b0);
    issue(32, T_XOR, 32'h8000_0000, 32'h0000_0001, mk(32'h8000_0001, 4'b1000), 1'b0);
    drain(32);

    // 32-bit multiply wraps modulo 2^32; latency WIDTH+1
    issue(32, T_MUL, 32'h0001_0000, 32'h0001_0000, mk(32'h0000_0000, 4'b0100), 1'b0);
    measure(32, lat, bcnt, rcnt);
    check("mul32_latency", lat, 33);
    check("mul32_busy_cycles", bcnt, 32);
    sync();
    drain(32);

    // Back-pressure: result held stable in DONE, then four ADDs stream one per cycle
    base = pops32.size();
    ordy32 = 1'b0;
    issue(32, T_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 4'b1001), 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", ov32, 1'b1);
      check("bp_result_held", res32, 32'h8000_0000);
      check("bp_nzcv_held", {n32, z32, c32, o32}, 4'b1001);
      check("bp_in_ready", rdy32, 1'b0);
    end
    sync();
    ordy32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra = 32'h1000_0001 * (i + 1);
      rb = 32'(i + 3);
      issue(32, T_ADD, ra, rb, model(32, T_ADD, ra, rb), 1'b0);
    end
    drain(32);
    check("tput_pop_count", pops32.size() - base, 5);
    for (int k = 1; k < 5; k++)
      check("tput_gap", pops32[base + k] - pops32[base + k - 1], 1);

    // WIDTH=8 multiply latency, busy window and in_ready low throughout
    issue(8, T_MUL, 32'h0F, 32'h11, mk(32'h0000_00FF, 4'b1000), 1'b0);
    measure(8, lat, bcnt, rcnt);
    check("mul8_latency", lat, 9);
    check("mul8_busy_cycles", bcnt, 8);
    check("mul8_in_ready_high_cycles", rcnt, 0);
    sync();
    drain(8);

    // Reset in the middle of a multiply discards it
    issue(8, T_MUL, 32'h0F, 32'h11, mk(32'h0000_00FF, 4'b1000), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    sync();
    rst8_n = 1'b1;
    q8.delete();
    @(negedge clk);
    check("midrst_out_valid", ov8, 1'b0);
    check("midrst_busy", busy8, 1'b0);
    check("midrst_result", res8, 8'd0);
    check("midrst_in_ready", rdy8, 1'b1);
    sync();
    issue(8, T_ADD, 32'h7F, 32'h01, mk(32'h0000_0080, 4'b1001), 1'b0);
    measure(8, lat, bcnt, rcnt);
    check("post_rst_add_latency", lat, 1);
    sync();
    drain(8);

    // Random ops with random back-pressure on both widths
    for (int w = 8; w <= 32; w += 24) begin
      for (int i = 0; i < 30; i++) begin
        op = 3'($urandom_range(0, 7));
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 5))
          0: ra = '0;
          1: rb = '1;
          2: ra = 32'h8000_0080;
          default: ;
        endcase
        repeat ($urandom_range(0, 1)) begin
          sync();
          set_ordy(w, ($urandom_range(0, 2) != 0));
        end
        issue(w, op, ra, rb, model(w, op, ra, rb), 1'b1);
      end
      drain(w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
